// File: rtl/subckt_bist_sequencer.sv
// BIST sequencer for a flop-based sub-circuit under test: holds the CUT in reset,
// streams LFSR patterns into it, compacts its output into a MISR and grades the signature.
module subckt_bist_sequencer #(
    parameter int             IN_W      = 7,
    parameter int             LAT       = 2,
    parameter int             CNT_W     = 10,
    parameter int             SIG_W     = 16,
    parameter logic [IN_W-1:0] LFSR_SEED = 7'h7F
) (
    input  logic              I1470_clk,
    input  logic              I1477_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [SIG_W-1:0]  golden_sig,
    output logic [IN_W-1:0]   cut_in,
    output logic              cut_rst,
    input  logic              cut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [SIG_W-1:0]  sig
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_APPLY,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_reg;
    logic [IN_W-1:0]  lfsr;
    logic [LAT-1:0]   vld_p;

    function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] l);
        return {l[IN_W-2:0], l[IN_W-1] ^ l[IN_W-2]};
    endfunction

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s, input logic b);
        return {s[SIG_W-2:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ b};
    endfunction

    always_ff @(posedge I1470_clk or posedge I1477_rst) begin
        if (I1477_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt counts cycles spent in the current state; it restarts on every transition
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && num_patterns != '0) state_nxt = S_INIT;
            S_INIT:  if (cnt == CNT_W'(1)) state_nxt = S_APPLY;
            S_APPLY: if (cnt == n_reg - 1'b1) state_nxt = S_DRAIN;
            S_DRAIN: if (cnt == CNT_W'(LAT - 1)) state_nxt = S_CHECK;
            S_CHECK: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
        busy = (state == S_INIT) || (state == S_APPLY) || (state == S_DRAIN) || (state == S_CHECK);
        done = (state == S_DONE);
    end

    // CUT-facing outputs are registered from the next state so they line up with it
    always_ff @(posedge I1470_clk or posedge I1477_rst) begin
        if (I1477_rst) begin
            cnt     <= '0;
            n_reg   <= '0;
            lfsr    <= LFSR_SEED;
            vld_p   <= '0;
            cut_in  <= '0;
            cut_rst <= 1'b1;
            sig     <= '0;
            pass    <= 1'b0;
            fail    <= 1'b0;
        end else begin
            cnt     <= (state_nxt != state) ? '0 : cnt + 1'b1;
            cut_rst <= !((state_nxt == S_APPLY) || (state_nxt == S_DRAIN));
            cut_in  <= (state_nxt == S_APPLY) ? lfsr : '0;

            if (state_nxt == S_INIT) begin
                lfsr <= LFSR_SEED;
            end else if (state_nxt == S_APPLY) begin
                lfsr <= lfsr_step(lfsr);
            end

            // token marks the cycle in which the CUT response to an applied pattern is visible
            if (abort) begin
                vld_p <= '0;
            end else begin
                vld_p <= (vld_p << 1) | LAT'(state == S_APPLY);
            end

            if (state == S_INIT) begin
                sig <= '0;
            end else if (vld_p[LAT-1] && !abort) begin
                sig <= misr_step(sig, cut_out);
            end

            if (abort) begin
                pass <= 1'b0;
                fail <= 1'b0;
            end else if (state == S_IDLE && state_nxt == S_INIT) begin
                n_reg <= num_patterns;
                pass  <= 1'b0;
                fail  <= 1'b0;
            end else if (state == S_CHECK) begin
                pass <= (sig == golden_sig);
                fail <= (sig != golden_sig);
            end
        end
    end

endmodule

// File: tb/tb_subckt_bist_sequencer.sv
// Bench for subckt_bist_sequencer: vector table, cycle-accurate reference model and corner sequences.
module tb_subckt_bist_sequencer;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [9:0]  num_patterns;
    logic [15:0] golden_sig;
    logic [6:0]  cut_in;
    logic        cut_rst;
    logic        cut_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic        fail;
    logic [15:0] sig;

    int checks = 0;
    int errors = 0;

    subckt_bist_sequencer dut (
        .I1470_clk    (clk),
        .I1477_rst    (rst),
        .start        (start),
        .abort        (abort),
        .num_patterns (num_patterns),
        .golden_sig   (golden_sig),
        .cut_in       (cut_in),
        .cut_rst      (cut_rst),
        .cut_out      (cut_out),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .sig          (sig)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [6:0] lfsr_next(input logic [6:0] x);
        return 7'(((x << 1) & 7'h7F) | 7'(x[6] ^ x[5]));
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic b);
        return 16'((s << 1) | 16'((^(s & 16'hB400)) ^ b));
    endfunction

    task automatic chk_idle_outputs(input string tag, input int cyc);
        chk({tag, ".cut_rst"}, cyc, 32'(cut_rst), 32'd1);
        chk({tag, ".busy"},    cyc, 32'(busy),    32'd0);
        chk({tag, ".done"},    cyc, 32'(done),    32'd0);
        chk({tag, ".cut_in"},  cyc, 32'(cut_in),  32'd0);
    endtask

    // mode: 0/1 = cut_out tied, 2 = random. gsel: 0 = gfix, 1 = model signature, 2 = corrupted model signature.
    task automatic run_seq(input int n, input int mode, input int gsel, input logic [15:0] gfix,
                           input bit noise, output logic [15:0] sig_o, output logic pass_o);
        logic [6:0]  l;
        logic [15:0] ms;
        logic [15:0] gold;
        logic        b;
        logic        exp_pass;
        int          total;
        l = 7'h7F;
        ms = '0;
        gold = gfix;
        exp_pass = 1'b0;
        total = n + LAT + 4;
        num_patterns = 10'(n);
        golden_sig = gfix;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= total + 1; c++) begin
            b = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
            cut_out = b;
            start = noise && (c == 4 || c == 5);
            if (c == total - 1 && gsel != 0) begin
                gold = (gsel == 1) ? ms : ms ^ 16'($urandom_range(1, 65535));
                golden_sig = gold;
            end
            if (c == total) exp_pass = (ms == gold);
            @(negedge clk);
            chk("busy",    c, 32'(busy),    32'(c <= total - 1));
            chk("done",    c, 32'(done),    32'(c == total));
            chk("cut_rst", c, 32'(cut_rst), 32'(!(c >= 3 && c <= n + LAT + 2)));
            chk("cut_in",  c, 32'(cut_in),  32'((c >= 3 && c <= n + 2) ? l : 7'h0));
            if (c >= 2) chk("sig", c, 32'(sig), 32'(ms));
            chk("pass", c, 32'(pass), 32'((c >= total) ? exp_pass : 1'b0));
            chk("fail", c, 32'(fail), 32'((c >= total) ? !exp_pass : 1'b0));
            if (c >= 3 && c <= n + 2) l = lfsr_next(l);
            if (c >= 3 + LAT && c <= n + 2 + LAT) ms = misr_next(ms, b);
            @(posedge clk); #1;
        end
        start = 1'b0;
        sig_o = sig;
        pass_o = pass;
    endtask

    typedef struct {
        int          n;
        int          mode;
        logic [15:0] golden;
        logic [15:0] exp_sig;
        logic        exp_pass;
    } vec_t;

    vec_t        tbl[6];
    logic [15:0] s_got;
    logic        p_got;

    initial begin
        tbl[0] = '{n: 4,  mode: 1, golden: 16'h000F, exp_sig: 16'h000F, exp_pass: 1'b1};
        tbl[1] = '{n: 3,  mode: 1, golden: 16'h0007, exp_sig: 16'h0007, exp_pass: 1'b1};
        tbl[2] = '{n: 3,  mode: 1, golden: 16'h0006, exp_sig: 16'h0007, exp_pass: 1'b0};
        tbl[3] = '{n: 1,  mode: 0, golden: 16'h0000, exp_sig: 16'h0000, exp_pass: 1'b1};
        tbl[4] = '{n: 5,  mode: 1, golden: 16'h0000, exp_sig: 16'h001F, exp_pass: 1'b0};
        tbl[5] = '{n: 12, mode: 1, golden: 16'h0FFE, exp_sig: 16'h0FFE, exp_pass: 1'b1};

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        num_patterns = '0;
        golden_sig = '0;
        cut_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("rst_held", 0);
        chk("rst_held.sig",  0, 32'(sig),  32'h0);
        chk("rst_held.pass", 0, 32'(pass), 32'd0);
        chk("rst_held.fail", 0, 32'(fail), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_idle_outputs("rst_rel", 0);
        chk("rst_rel.sig",  0, 32'(sig),  32'h0);
        chk("rst_rel.pass", 0, 32'(pass), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_seq(tbl[i].n, tbl[i].mode, 0, tbl[i].golden, 1'b0, s_got, p_got);
            chk($sformatf("tbl%0d.sig", i),  i, 32'(s_got), 32'(tbl[i].exp_sig));
            chk($sformatf("tbl%0d.pass", i), i, 32'(p_got), 32'(tbl[i].exp_pass));
        end

        // zero count: ignored, sticky result untouched
        num_patterns = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk_idle_outputs("zero_n", c);
            chk("zero_n.pass", c, 32'(pass), 32'd1);
            @(posedge clk); #1;
        end

        // abort in IDLE clears the sticky result
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle.pass", 0, 32'(pass), 32'd0);
        chk("abort_idle.fail", 0, 32'(fail), 32'd0);

        // abort in the second APPLY cycle
        num_patterns = 10'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort.pre_busy", 4, 32'(busy), 32'd1);
        chk("abort.pre_cut_in", 4, 32'(cut_in), 32'h7E);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk_idle_outputs("abort", 5);
        chk("abort.pass", 5, 32'(pass), 32'd0);
        chk("abort.fail", 5, 32'(fail), 32'd0);
        for (int c = 6; c <= 14; c++) begin
            @(posedge clk); #1;
            chk_idle_outputs("abort_after", c);
        end

        // start together with abort stays in IDLE
        num_patterns = 10'd5;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk_idle_outputs("start_abort", c);
            @(posedge clk); #1;
        end

        // start pulses while busy are ignored
        run_seq(6, 2, 1, 16'h0, 1'b1, s_got, p_got);
        chk("noise.pass", 0, 32'(p_got), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_seq($urandom_range(1, 40), 2, $urandom_range(1, 2), 16'h0, 1'b0, s_got, p_got);
        end

        // largest count, no counter wrap
        run_seq(1023, 2, 1, 16'h0, 1'b0, s_got, p_got);
        chk("max_n.pass", 0, 32'(p_got), 32'd1);

        // asynchronous reset in the middle of DRAIN
        num_patterns = 10'd4;
        golden_sig = '0;
        cut_out = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_drain.pre_sig",  7, 32'(sig),  32'h0003);
        chk("rst_drain.pre_busy", 7, 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst_drain", 7);
        chk("rst_drain.sig",  7, 32'(sig),  32'h0);
        chk("rst_drain.pass", 7, 32'(pass), 32'd0);
        chk("rst_drain.fail", 7, 32'(fail), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 9; c <= 12; c++) begin
            @(posedge clk); #1;
            chk_idle_outputs("rst_drain_after", c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/subckt_bist_sequencer.md
Name: subckt_bist_sequencer

Overview:
- Built-in self-test controller for one flop-based Nt-node sub-circuit under test (CUT) in the trojan-detection benchmark set.
- Holds the CUT in reset, then drives its data inputs with an LFSR pattern stream for a programmed number of cycles.
- Compacts the CUT output into a serial signature register (MISR), compares it against a golden signature, and reports pass/fail.
- Sits between the benchmark harness (start/abort/config) and the CUT's data, clock-enable and reset pins.

Parameters:
- IN_W, 7, CUT data-input width.
- LAT, 2, CUT input-to-output latency in clocks; range 1..7.
- CNT_W, 10, pattern-count width.
- SIG_W, 16, signature width; feedback taps are fixed for 16.
- LFSR_SEED, 7'h7F, LFSR value loaded in INIT; must be nonzero.

Ports:
- I1470_clk  in  1  Single clock; all flops rising-edge.
- I1477_rst  in  1  Reset, asynchronous, active-high; clears every flop.
- start  in  1  Begin a run; sampled only in IDLE.
- abort  in  1  Synchronous abort; returns to IDLE from any state.
- num_patterns  in  CNT_W  Vector count N, captured at start.
- golden_sig  in  SIG_W  Expected signature, sampled in CHECK.
- cut_in  out  IN_W  Registered stimulus to the CUT.
- cut_rst  out  1  Active-high reset to the CUT.
- cut_out  in  1  CUT observed output.
- busy  out  1  High in INIT, APPLY, DRAIN and CHECK.
- done  out  1  One-cycle pulse in DONE.
- pass  out  1  Sticky result, cleared on next accepted start, abort or reset.
- fail  out  1  Sticky result, cleared on next accepted start, abort or reset.
- sig  out  SIG_W  Current MISR value.

Behaviour:
- Reset values: state=IDLE, cut_in=0, cut_rst=1, busy=0, done=0, pass=0, fail=0, sig=0, lfsr=LFSR_SEED.
- States: IDLE -> INIT -> APPLY -> DRAIN -> CHECK -> DONE -> IDLE.
- IDLE
  - start=1 and num_patterns!=0: latch N, clear pass/fail, go to INIT.
  - start=1 and num_patterns==0: ignored; no done.
- INIT: exactly 2 cycles. cut_rst=1, lfsr<=LFSR_SEED, sig<=0, cut_in=0.
- APPLY: exactly N cycles. cut_rst=0.
  - cut_in<=lfsr each cycle.
  - lfsr<={lfsr[5:0], lfsr[6]^lfsr[5]}.
  - A valid token enters a LAT-deep shift pipe.
- DRAIN: exactly LAT cycles. cut_in=0, cut_rst=0, LFSR frozen.
- Compaction
  - Each cycle in which the token emerges from the pipe: sig<={sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]^cut_out}.
  - Exactly N compaction cycles occur, the last in the final DRAIN cycle.
- CHECK: one cycle. pass<=(sig==golden_sig), fail<=~(sig==golden_sig).
- DONE: one cycle. done=1, cut_rst=1; then IDLE. sig holds until the next INIT.
- Timing: start sampled at edge 0 gives done high in cycle N+LAT+4. N=2^CNT_W-1 needs no counter wrap.
- start while busy: ignored.
- abort
  - Takes priority over every transition, including a simultaneous start in IDLE.
  - Next state IDLE; cut_rst=1, cut_in=0, pass=fail=0, token pipe cleared, no done.
- Asynchronous reset mid-run: immediate return to reset values; no done.

Test Plan:
- Reset asserted, then released: cut_rst=1, busy=0, sig=0000, pass=fail=0.
- LAT=2, N=4, start pulse: cut_in=7F,7E,7C,78 on APPLY cycles 3-6; cut_in=0 in DRAIN; done high in cycle 10 only; busy high cycles 1-9.
- N=3, cut_out tied 1, golden=0007 -> sig=0001,0003,0007, pass=1, fail=0. Repeat with golden=0006 -> fail=1, pass=0.
- N=1, cut_out tied 0, golden=0000 -> pass=1, done in cycle 7; start with num_patterns=0 -> state stays IDLE, busy=0, no done.
- abort in the 2nd APPLY cycle -> next cycle IDLE, cut_rst=1, busy=0, no done, pass=fail=0; start re-issued together with abort -> stays IDLE.
- start pulses at cycles 4 and 5 during a run -> ignored, single done; I1477_rst asserted mid-DRAIN -> all outputs at reset values without a clock edge.
